gray_wptr_full: RTL and testbench

Write-side pointer and full-flag block for the team's asynchronous FIFO; this is the encoder end of the gray-pointer crossing.
- Keeps a binary write counter and publishes it as a registered gray-coded pointer for the read domain.
- Synchronizes the read domain's gray pointer into this clock domain.
- Produces full, accept and fill-level signals for the writer.
- Sits between the write client and the dual-port RAM write port.

---
 rtl/gray_pkg.sv | 24 ++
 rtl/sync_bus.sv | 37 +++
 rtl/gray_wptr_full.sv | 71 +++++++
 tb/tb_gray_wptr_full.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// Shared gray-code helpers for both ends of the async FIFO pointer crossing.
// Functions work on a wide fixed vector; callers zero-extend and size-cast.
package gray_pkg;

  localparam int DEFAULT_ADDR_W = 3;
  localparam int MAX_W          = 32;

  typedef logic [MAX_W-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t v);
    return v ^ (v >> 1);
  endfunction

  // Prefix-XOR from the MSB down.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b[MAX_W-1] = g[MAX_W-1];
    for (int i = MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Plain multi-flop synchronizer with synchronous active-high clear.
// Safe for a bus only when at most one bit changes at a time (gray code).
module sync_bus #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_d [STAGES];
  logic [WIDTH-1:0] stage_q [STAGES];

  // Pure wiring between stages; nothing may sit between the flops.
  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // NOTE: non-blocking assignments so every stage samples the pre-edge value of its neighbour.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_wptr_full.sv
// Write-side pointer, full flag and fill level for the async FIFO.
// Publishes a registered gray write pointer; synchronizes the read gray pointer in.
module gray_wptr_full
  import gray_pkg::*;
#(
  parameter int ADDR_W      = DEFAULT_ADDR_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rptr_gray_async,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic [ADDR_W:0]   level
);

  localparam int PW = ADDR_W + 1;

  logic [ADDR_W:0] rq;
  logic [ADDR_W:0] rbin;
  logic [ADDR_W:0] wbin_d,  wbin_q;
  logic [ADDR_W:0] wgray_d, wgray_q;
  logic [ADDR_W:0] level_d, level_q;
  logic            full_d,  full_q;
  logic            push;

  sync_bus #(
    .WIDTH  (PW),
    .STAGES (SYNC_STAGES)
  ) u_rptr_sync (
    .clk (clk),
    .rst (rst),
    .d   (rptr_gray_async),
    .q   (rq)
  );

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    push    = wr_en & ~full_q;
    wbin_d  = wbin_q + PW'(push);
    wgray_d = PW'(bin2gray(ptr_t'(wbin_d)));
    rbin    = PW'(gray2bin(ptr_t'(rq)));
    // Full when the writer is exactly one lap ahead: top two gray bits inverted.
    full_d  = (wgray_d == {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]});
    level_d = wbin_d - rbin;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      level_q <= '0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      level_q <= level_d;
    end
  end

  assign wr_ack    = push;
  assign waddr     = wbin_q[ADDR_W-1:0];
  assign wptr_gray = wgray_q;
  assign full      = full_q;
  assign level     = level_q;

endmodule

// File: tb/tb_gray_wptr_full.sv
// Self-checking bench for gray_wptr_full (ADDR_W=3, SYNC_STAGES=2).
// A cycle model predicts registered outputs into a queue; scenario tasks add literal checks.
module tb_gray_wptr_full;

  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [3:0] rptr_gray_async = '0;
  logic       wr_ack;
  logic [2:0] waddr;
  logic [3:0] wptr_gray;
  logic       full;
  logic [3:0] level;

  gray_wptr_full #(.ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .wr_en           (wr_en),
    .rptr_gray_async (rptr_gray_async),
    .wr_ack          (wr_ack),
    .waddr           (waddr),
    .wptr_gray       (wptr_gray),
    .full            (full),
    .level           (level)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] gray;
    logic       full;
    logic [3:0] level;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  // Model state
  logic [3:0] m_wbin  = '0;
  logic       m_full  = 1'b0;
  logic [3:0] m_sync0 = '0;
  logic [3:0] m_sync1 = '0;

  logic       last_ack;
  logic       last_full;
  logic [2:0] last_waddr;

  function automatic logic [3:0] b2g(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b = '0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i; j < 4; j++) b[i] = b[i] ^ g[j];
    end
    return b;
  endfunction

  // One clock: drive at negedge, check combinational outputs, predict, check after posedge.
  task automatic drive_cycle(input logic en, input logic r, input logic [3:0] rp, input bit comb_chk);
    logic       exp_ack;
    logic [3:0] nxt;
    logic [3:0] lvl;
    exp_t       e;
    exp_t       got;
    @(negedge clk);
    wr_en = en;
    rst = r;
    rptr_gray_async = rp;
    #1;
    exp_ack = en & ~m_full;
    last_ack = wr_ack;
    last_full = full;
    last_waddr = waddr;
    if (comb_chk) begin
      checks++;
      if (wr_ack !== exp_ack) begin
        errors++;
        $display("FAIL wr_ack: got %b expected %b (t=%0t)", wr_ack, exp_ack, $time);
      end
      checks++;
      if (waddr !== m_wbin[2:0]) begin
        errors++;
        $display("FAIL waddr: got %0d expected %0d (t=%0t)", waddr, m_wbin[2:0], $time);
      end
    end
    if (r) begin
      m_wbin = '0; m_full = 1'b0; m_sync0 = '0; m_sync1 = '0;
      e = '{gray: 4'd0, full: 1'b0, level: 4'd0};
    end else begin
      nxt = m_wbin + {3'b0, exp_ack};
      lvl = nxt - g2b(m_sync1);
      m_wbin = nxt;
      m_full = (lvl == 4'(DEPTH));
      m_sync1 = m_sync0;
      m_sync0 = rp;
      e = '{gray: b2g(nxt), full: m_full, level: lvl};
    end
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    checks++;
    if (wptr_gray !== got.gray) begin
      errors++;
      $display("FAIL sb_wptr_gray: got %0d expected %0d (t=%0t)", wptr_gray, got.gray, $time);
    end
    checks++;
    if (full !== got.full) begin
      errors++;
      $display("FAIL sb_full: got %b expected %b (t=%0t)", full, got.full, $time);
    end
    checks++;
    if (level !== got.level) begin
      errors++;
      $display("FAIL sb_level: got %0d expected %0d (t=%0t)", level, got.level, $time);
    end
  endtask

  task automatic test_reset();
    drive_cycle(1'b1, 1'b1, 4'd0, 1'b0);
    drive_cycle(1'b1, 1'b1, 4'd0, 1'b1);
    checks++;
    if (wptr_gray !== 4'd0 || waddr !== 3'd0 || full !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: got gray=%0d waddr=%0d full=%b level=%0d expected all 0",
               wptr_gray, waddr, full, level);
    end
    @(negedge clk);
    wr_en = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_wr_ack: got %b expected 0", wr_ack);
    end
  endtask

  task automatic test_fill();
    logic [3:0] seq [8];
    seq = '{4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4, 4'd12};
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b1, 1'b0, 4'd0, 1'b1);
      checks++;
      if (last_ack !== 1'b1 || last_waddr !== 3'(i) || wptr_gray !== seq[i]) begin
        errors++;
        $display("FAIL fill_%0d: got ack=%b waddr=%0d gray=%0d expected ack=1 waddr=%0d gray=%0d",
                 i, last_ack, last_waddr, wptr_gray, i, seq[i]);
      end
    end
    checks++;
    if (full !== 1'b1 || level !== 4'd8) begin
      errors++;
      $display("FAIL fill_full: got full=%b level=%0d expected full=1 level=8", full, level);
    end
    drive_cycle(1'b1, 1'b0, 4'd0, 1'b1);
    checks++;
    if (last_ack !== 1'b0 || wptr_gray !== 4'd12) begin
      errors++;
      $display("FAIL fill_reject: got ack=%b gray=%0d expected ack=0 gray=12", last_ack, wptr_gray);
    end
  endtask

  task automatic test_release();
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0, 1'b0, 4'b0001, 1'b1);
      checks++;
      if (i < 2 && full !== 1'b1) begin
        errors++;
        $display("FAIL release_early_%0d: got full=%b expected 1", i, full);
      end else if (i == 2 && (full !== 1'b0 || level !== 4'd7)) begin
        errors++;
        $display("FAIL release_third_edge: got full=%b level=%0d expected full=0 level=7", full, level);
      end
    end
    drive_cycle(1'b1, 1'b0, 4'b0001, 1'b1);
    checks++;
    if (last_ack !== 1'b1 || last_waddr !== 3'd0 || wptr_gray !== 4'd13 || full !== 1'b1) begin
      errors++;
      $display("FAIL release_push: got ack=%b waddr=%0d gray=%0d full=%b expected ack=1 waddr=0 gray=13 full=1",
               last_ack, last_waddr, wptr_gray, full);
    end
  endtask

  task automatic test_wrap();
    logic [3:0] prev;
    bit         seen_wrap;
    seen_wrap = 1'b0;
    for (int i = 0; i < 24; i++) begin
      prev = wptr_gray;
      drive_cycle(1'b1, 1'b0, b2g(m_wbin - 4'd4), 1'b1);
      if (prev == 4'd8 && wptr_gray == 4'd0) seen_wrap = 1'b1;
      if (i >= 3) begin
        checks++;
        if (full !== 1'b0 || level > 4'd7) begin
          errors++;
          $display("FAIL wrap_trail_%0d: got full=%b level=%0d expected full=0 level<=7", i, full, level);
        end
      end
    end
    checks++;
    if (!seen_wrap) begin
      errors++;
      $display("FAIL wrap_seen: got no 8->0 gray transition expected one");
    end
  endtask

  task automatic test_mid_reset();
    drive_cycle(1'b0, 1'b1, 4'd0, 1'b1);
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 4'd0, 1'b1);
    drive_cycle(1'b1, 1'b1, 4'b0011, 1'b1);
    checks++;
    if (wptr_gray !== 4'd0 || waddr !== 3'd0 || full !== 1'b0 || level !== 4'd0) begin
      errors++;
      $display("FAIL midreset_state: got gray=%0d waddr=%0d full=%b level=%0d expected all 0",
               wptr_gray, waddr, full, level);
    end
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b0, 1'b0, 4'b0011, 1'b1);
      checks++;
      if (level !== 4'd0) begin
        errors++;
        $display("FAIL midreset_sync_clear_%0d: got level=%0d expected 0", i, level);
      end
    end
    drive_cycle(1'b0, 1'b1, 4'd0, 1'b1);
  endtask

  task automatic test_random_single_bit();
    logic [3:0] prev;
    logic [3:0] r_bin;
    logic       en;
    r_bin = '0;
    for (int i = 0; i < 1000; i++) begin
      if ((m_wbin - r_bin) != 4'd0 && $urandom_range(0, 2) == 0) r_bin = r_bin + 4'd1;
      en = 1'($urandom_range(0, 3) != 0);
      prev = wptr_gray;
      drive_cycle(en, 1'b0, b2g(r_bin), 1'b1);
      checks++;
      if ($countones(wptr_gray ^ prev) > 1 || level > 4'(DEPTH) || (last_ack && last_full)) begin
        errors++;
        $display("FAIL random_%0d: got prev=%0d gray=%0d level=%0d ack=%b full=%b",
                 i, prev, wptr_gray, level, last_ack, last_full);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_release();
    test_wrap();
    test_mid_reset();
    test_random_single_bit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
